// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of the single-port SRAM, with a
// watchdog that turns a stalled slave into an error completion.
module mem_arbiter #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        bus_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic        busy;
  logic        sel;
  logic        timeout_hit;
  logic        done;
  logic [31:0] rsp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;

    busy = (state_q == BUSY);
    // On a tie the master that was not served last wins; otherwise whoever asks.
    sel  = (m0_valid && m1_valid) ? ~last_q : m1_valid;
    // s_ready has priority over the watchdog when both land in the same cycle.
    timeout_hit = busy && !s_ready && (cnt_q == CNT_LAST);
    done        = busy && (s_ready || timeout_hit);

    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = BUSY;
          gnt_d   = sel;
          last_d  = sel;
          cnt_d   = 8'd0;
          addr_d  = sel ? m1_addr  : m0_addr;
          wdata_d = sel ? m1_wdata : m0_wdata;
          wstrb_d = sel ? m1_wstrb : m0_wstrb;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (done) begin
          state_d = IDLE;
        end
      end
    endcase

    rsp_data = timeout_hit ? ERR_DATA : s_rdata;
  end

  // Valid drops combinationally with ready so a registered-ready slave never
  // sees a second access.
  assign s_valid  = busy && !s_ready && !timeout_hit;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;
  assign m0_ready = done && !gnt_q;
  assign m1_ready = done && gnt_q;
  assign m0_rdata = rsp_data;
  assign m1_rdata = rsp_data;
  assign bus_err  = timeout_hit;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for the basic flows plus
// hand sequences for ties, timeout, coincident ready and mid-transfer reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_valid = 1'b0;
  logic [31:0] m0_addr = 32'd0;
  logic [31:0] m0_wdata = 32'd0;
  logic [3:0]  m0_wstrb = 4'd0;
  logic [31:0] m0_rdata;
  logic        m0_ready;
  logic        m1_valid = 1'b0;
  logic [31:0] m1_addr = 32'd0;
  logic [31:0] m1_wdata = 32'd0;
  logic [3:0]  m1_wstrb = 4'd0;
  logic [31:0] m1_rdata;
  logic        m1_ready;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata = 32'h5A5A_0000;
  logic        s_ready = 1'b0;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // SRAM model: ready 'lat' cycles after valid first seen, or never when hung.
  logic [31:0] mem [16] = '{32'h0, 32'h1122_3344, 32'h2, 32'h3,
                            32'h1234_5678, 32'h5, 32'h6, 32'h7,
                            32'h0BAD_F00D, 32'hCAFE_0009, 32'hA, 32'hB,
                            32'hC, 32'hD, 32'hE, 32'hF};
  logic hang = 1'b0;
  int   lat  = 1;
  int   wcnt = 0;

  always @(posedge clk) begin
    if (s_valid && !s_ready) begin
      if (!hang && (wcnt + 1 == lat)) begin
        s_ready <= 1'b1;
        wcnt    <= 0;
        if (s_wstrb == 4'b0000) begin
          s_rdata <= mem[s_addr[5:2]];
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (s_wstrb[b]) mem[s_addr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
          end
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      s_ready <= 1'b0;
      wcnt    <= 0;
    end
  end

  typedef struct {
    logic [1:0]  mv;    // {m0_valid, m1_valid}
    logic [31:0] m0a;
    logic [31:0] m1a;
    logic [31:0] m1d;
    logic [3:0]  m1s;
    logic [2:0]  eo;    // expected {s_valid, m0_ready, m1_ready}
    logic [1:0]  fl;    // {check payload, check rdata}
    logic [31:0] ea;
    logic [31:0] ed;
    logic [3:0]  es;
    logic [31:0] er;
  } vec_t;

  function automatic vec_t mk(logic [1:0] mv, logic [31:0] m0a, logic [31:0] m1a,
                              logic [31:0] m1d, logic [3:0] m1s, logic [2:0] eo,
                              logic [1:0] fl, logic [31:0] ea, logic [31:0] ed,
                              logic [3:0] es, logic [31:0] er);
    vec_t v;
    v.mv = mv; v.m0a = m0a; v.m1a = m1a; v.m1d = m1d; v.m1s = m1s;
    v.eo = eo; v.fl = fl; v.ea = ea; v.ed = ed; v.es = es; v.er = er;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Steps negedge by negedge until a ready shows; who=-1 if the bound expires.
  task automatic wait_ready(output int who, output int ncyc);
    who  = -1;
    ncyc = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      #1;
      if (m0_ready || m1_ready) begin
        who  = (m0_ready && m1_ready) ? 2 : (m1_ready ? 1 : 0);
        ncyc = n;
        break;
      end
    end
  endtask

  vec_t vecs [18];
  int   who;
  int   ncyc;
  int   exp_owner;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(2'b01, 0,     'h10, 0,           4'h0,    3'b000, 2'b00, 0,     0,           4'h0,    0);
    vecs[1]  = mk(2'b01, 0,     'h10, 0,           4'h0,    3'b100, 2'b10, 'h10,  0,           4'h0,    0);
    vecs[2]  = mk(2'b01, 0,     'h10, 0,           4'h0,    3'b001, 2'b01, 0,     0,           4'h0,    'h1234_5678);
    vecs[3]  = mk(2'b00, 0,     0,    0,           4'h0,    3'b000, 2'b00, 0,     0,           4'h0,    0);
    vecs[4]  = mk(2'b11, 'h20,  'h24, 0,           4'h0,    3'b000, 2'b00, 0,     0,           4'h0,    0);
    vecs[5]  = mk(2'b11, 'h20,  'h24, 0,           4'h0,    3'b100, 2'b10, 'h20,  0,           4'h0,    0);
    vecs[6]  = mk(2'b11, 'h20,  'h24, 0,           4'h0,    3'b010, 2'b01, 0,     0,           4'h0,    'h0BAD_F00D);
    vecs[7]  = mk(2'b01, 0,     'h24, 0,           4'h0,    3'b000, 2'b00, 0,     0,           4'h0,    0);
    vecs[8]  = mk(2'b01, 0,     'h24, 0,           4'h0,    3'b100, 2'b10, 'h24,  0,           4'h0,    0);
    vecs[9]  = mk(2'b01, 0,     'h24, 0,           4'h0,    3'b001, 2'b01, 0,     0,           4'h0,    'hCAFE_0009);
    vecs[10] = mk(2'b01, 0,     'h4,  'hAABB_CCDD, 4'b0010, 3'b000, 2'b00, 0,     0,           4'h0,    0);
    vecs[11] = mk(2'b01, 0,     'h4,  'hAABB_CCDD, 4'b0010, 3'b100, 2'b10, 'h4,   'hAABB_CCDD, 4'b0010, 0);
    vecs[12] = mk(2'b01, 0,     'h4,  'hAABB_CCDD, 4'b0010, 3'b001, 2'b00, 0,     0,           4'h0,    0);
    vecs[13] = mk(2'b00, 0,     0,    0,           4'h0,    3'b000, 2'b00, 0,     0,           4'h0,    0);
    vecs[14] = mk(2'b10, 'h4,   0,    0,           4'h0,    3'b000, 2'b00, 0,     0,           4'h0,    0);
    vecs[15] = mk(2'b10, 'h4,   0,    0,           4'h0,    3'b100, 2'b10, 'h4,   0,           4'h0,    0);
    vecs[16] = mk(2'b10, 'h4,   0,    0,           4'h0,    3'b010, 2'b01, 0,     0,           4'h0,    'h1122_CC44);
    vecs[17] = mk(2'b00, 0,     0,    0,           4'h0,    3'b000, 2'b00, 0,     0,           4'h0,    0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_s_valid", s_valid, 1'b0);
    chk32("rst_s_addr", s_addr, 32'h0);
    chk32("rst_s_wdata", s_wdata, 32'h0);
    chk32("rst_s_wstrb", 32'(s_wstrb), 32'h0);
    chk1("rst_m0_ready", m0_ready, 1'b0);
    chk1("rst_m1_ready", m1_ready, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk32("rst_m0_rdata", m0_rdata, 32'h5A5A_0000);
    @(negedge clk);
    rst = 1'b0;

    // Cycle table: single read, tie, byte write and read-back
    for (int i = 0; i < 18; i++) begin
      {m0_valid, m1_valid} = vecs[i].mv;
      m0_addr  = vecs[i].m0a;
      m0_wdata = 32'h0;
      m0_wstrb = 4'h0;
      m1_addr  = vecs[i].m1a;
      m1_wdata = vecs[i].m1d;
      m1_wstrb = vecs[i].m1s;
      #1;
      chk1($sformatf("v%0d_s_valid", i), s_valid, vecs[i].eo[2]);
      chk1($sformatf("v%0d_m0_ready", i), m0_ready, vecs[i].eo[1]);
      chk1($sformatf("v%0d_m1_ready", i), m1_ready, vecs[i].eo[0]);
      chk1($sformatf("v%0d_bus_err", i), bus_err, 1'b0);
      if (vecs[i].fl[1]) begin
        chk32($sformatf("v%0d_s_addr", i), s_addr, vecs[i].ea);
        chk32($sformatf("v%0d_s_wdata", i), s_wdata, vecs[i].ed);
        chk32($sformatf("v%0d_s_wstrb", i), 32'(s_wstrb), 32'(vecs[i].es));
      end
      if (vecs[i].fl[0]) begin
        chk32($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].er);
        chk32($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].er);
      end
      @(negedge clk);
    end

    // 20 back-to-back ties; m0 was served last, so m1 leads
    m0_valid = 1'b1; m0_addr = 32'h20;
    m1_valid = 1'b1; m1_addr = 32'h24;
    exp_owner = 1;
    for (int i = 0; i < 20; i++) begin
      wait_ready(who, ncyc);
      chk32($sformatf("tie%0d_owner", i), 32'(who), 32'(exp_owner));
      chk32($sformatf("tie%0d_latency", i), 32'(ncyc), (i == 0) ? 32'd2 : 32'd3);
      exp_owner = 1 - exp_owner;
    end
    @(negedge clk);
    m0_valid = 1'b0;
    m1_valid = 1'b0;

    // Hung slave: error completion in cycle 16
    hang = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h8;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      if (k < 16) begin
        chk1($sformatf("to%0d_s_valid", k), s_valid, 1'b1);
        chk1($sformatf("to%0d_m0_ready", k), m0_ready, 1'b0);
        chk1($sformatf("to%0d_bus_err", k), bus_err, 1'b0);
      end else begin
        chk1("to_done_m0_ready", m0_ready, 1'b1);
        chk1("to_done_m1_ready", m1_ready, 1'b0);
        chk1("to_done_bus_err", bus_err, 1'b1);
        chk1("to_done_s_valid", s_valid, 1'b0);
        chk32("to_done_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      end
    end
    @(negedge clk);
    m0_valid = 1'b0;
    #1;
    chk1("to_idle_s_valid", s_valid, 1'b0);
    chk1("to_idle_m0_ready", m0_ready, 1'b0);
    chk1("to_idle_bus_err", bus_err, 1'b0);
    hang = 1'b0;
    m1_valid = 1'b1; m1_addr = 32'h10;
    wait_ready(who, ncyc);
    chk32("after_to_owner", 32'(who), 32'd1);
    chk32("after_to_latency", 32'(ncyc), 32'd2);
    chk32("after_to_rdata", m1_rdata, 32'h1234_5678);
    chk1("after_to_bus_err", bus_err, 1'b0);
    @(negedge clk);
    m1_valid = 1'b0;

    // Ready arrives exactly in the timeout cycle: normal completion wins
    lat = 15;
    m0_valid = 1'b1; m0_addr = 32'h24;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      if (k < 16) begin
        chk1($sformatf("co%0d_s_valid", k), s_valid, 1'b1);
        chk1($sformatf("co%0d_m0_ready", k), m0_ready, 1'b0);
      end else begin
        chk1("co_done_m0_ready", m0_ready, 1'b1);
        chk1("co_done_bus_err", bus_err, 1'b0);
        chk32("co_done_m0_rdata", m0_rdata, 32'hCAFE_0009);
      end
    end
    @(negedge clk);
    m0_valid = 1'b0;
    lat = 1;

    // Reset in the middle of a write's first BUSY cycle
    m0_valid = 1'b1; m0_addr = 32'h0; m0_wdata = 32'hFFFF_FFFF; m0_wstrb = 4'hF;
    @(negedge clk);
    #1;
    chk1("ar_busy_s_valid", s_valid, 1'b1);
    chk32("ar_busy_s_wstrb", 32'(s_wstrb), 32'hF);
    #1;
    rst = 1'b1;
    #1;
    chk1("ar_s_valid", s_valid, 1'b0);
    chk1("ar_m0_ready", m0_ready, 1'b0);
    chk1("ar_m1_ready", m1_ready, 1'b0);
    chk1("ar_bus_err", bus_err, 1'b0);
    chk32("ar_s_addr", s_addr, 32'h0);
    chk32("ar_s_wstrb", 32'(s_wstrb), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk32("ar_mem0_untouched", mem[0], 32'h0);
    m0_addr = 32'h10; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'h24;
    wait_ready(who, ncyc);
    chk32("ar_tie_owner", 32'(who), 32'd0);
    chk32("ar_tie_latency", 32'(ncyc), 32'd2);
    chk32("ar_tie_rdata", m0_rdata, 32'h1234_5678);
    @(negedge clk);
    m0_valid = 1'b0;
    m1_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave round-robin arbiter for the on-chip memory bus. It sits directly upstream of the single-port SRAM. It merges the CPU instruction-fetch port (m0) and data port (m1) onto the SRAM's valid/ready/addr/wdata/wstrb/rdata interface. A bus watchdog turns a hung slave into an error completion instead of a stalled core.

## Interface
Parameters:
- TIMEOUT, 16: cycles a granted transaction may wait for s_ready before error completion; legal range 2..255.
- ERR_DATA, 32'hDEAD_BEEF: read data returned to the master on a timeout completion.

Ports (clk first; reset is `rst`, one clock, asynchronous, active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- m0_valid  in  1  fetch request; held with its payload stable until m0_ready.
- m0_addr  in  32  fetch byte address.
- m0_wdata  in  32  fetch write data (normally unused).
- m0_wstrb  in  4  fetch byte strobes; 0000 means read.
- m0_rdata  out  32  response data, qualified by m0_ready.
- m0_ready  out  1  one-cycle completion pulse to m0.
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_ready: same as m0, for the data port.
- s_valid  out  1  request to SRAM.
- s_addr  out  32  latched address of the granted master.
- s_wdata  out  32  latched write data.
- s_wstrb  out  4  latched strobes.
- s_rdata  in  32  SRAM read data.
- s_ready  in  1  SRAM completion.
- bus_err  out  1  one-cycle pulse on timeout completion.

## Operation
- FSM has two states: IDLE and BUSY. Registers: `state`, `gnt` (0 = m0, 1 = m1), `last` (last granted master), `cnt` (timeout counter, 8 bits), and latched addr/wdata/wstrb.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request: grant that master.
- IDLE, both requests: grant the master that is not `last` (round-robin).
- On a grant edge:
  - latch the granted master's addr, wdata and wstrb into s_addr/s_wdata/s_wstrb;
  - set gnt, set last to gnt, clear cnt;
  - go to BUSY.
- In BUSY:
  - s_valid = ~s_ready. This is combinational, so valid drops in the same cycle ready is seen, which prevents a second access by a registered-ready slave.
  - cnt increments each cycle.
- Normal completion (BUSY and s_ready=1):
  - m{gnt}_ready = 1 combinationally, m{gnt}_rdata = s_rdata;
  - next state is IDLE.
- Timeout completion (BUSY, s_ready=0, cnt == TIMEOUT-1):
  - m{gnt}_ready = 1, m{gnt}_rdata = ERR_DATA, bus_err = 1;
  - s_valid = 0 in that cycle;
  - next state is IDLE.
- If s_ready and the timeout condition occur in the same cycle, s_ready wins: normal completion, no bus_err.
- The non-granted master's ready is always 0. m0_rdata and m1_rdata both carry the selected response (s_rdata, or ERR_DATA on timeout); each is valid only when its ready is 1.
- After a completion the FSM always passes through IDLE for at least one cycle. In the completion cycle the master still shows its old request, so that request must not be re-granted.
- s_ready arriving in IDLE is ignored: no ready to any master.
- Writes are passed through unchanged (wstrb latched); the arbiter does not interpret them.

## Timing
- Reset (async assert, sync-safe deassert by the system): state=IDLE, gnt=0, last=1 (so m0 wins the first tie), cnt=0, latched payload=0.
- Output values in reset: s_valid=0, s_addr=0, s_wdata=0, s_wstrb=0, m0_ready=m1_ready=0, bus_err=0. m*_rdata follows s_rdata.
- Reset asserted mid-BUSY: s_valid and all readies drop immediately, since they are combinational from state. No completion is signalled and the transaction is abandoned.
- With the 1-cycle SRAM:
  - cycle 0: m_valid sampled in IDLE;
  - cycle 1: s_valid=1;
  - cycle 2: s_ready=1 and m_ready=1;
  - cycle 3: IDLE.
- Request-to-ready latency is 2 cycles. Peak throughput is one transaction per 3 cycles.
- Timeout: with s_valid first high in cycle 1, the error completion occurs in cycle TIMEOUT (cnt counts 0..TIMEOUT-1).

## Test plan
- Single read: after reset, m1 reads 0x0000_0010 from an SRAM model holding 0x1234_5678 there. Required: s_valid high in cycle 1; m1_ready and m1_rdata=0x1234_5678 in cycle 2; m0_ready stays 0.
- Tie and round-robin: m0 and m1 both request in the same cycle after reset. Required: m0 is served first, then m1. The next tie goes to m0 again, because last=1 after serving m1. No master is starved over 20 alternating ties.
- Byte write: m1 writes addr 0x4, wdata 0xAABBCCDD, wstrb 0010. Required: s_wstrb=0010 and s_wdata latched. A read-back of word 1 shows only bits 15:8 = 0xCC changed. s_valid is high for exactly 1 cycle.
- Timeout: slave model never asserts s_ready, TIMEOUT=16. Required: m0_ready=1 with m0_rdata=0xDEADBEEF and bus_err=1 in cycle 16, then IDLE. A following normal read succeeds.
- Coincident s_ready and timeout: slave returns ready exactly in cycle TIMEOUT. Required: s_rdata is delivered and bus_err stays 0.
- Async reset mid-BUSY: assert rst between clock edges in cycle 1 of a write. Required: s_valid and readies go 0 before the next edge. After release, the first tie is granted to m0.
